// File: rtl/masked_sbox_feeder.sv
// Front end for the masked DOM aes_sbox: shares input bytes with PRNG masks and tracks them through the S-box.
// Define SBOX_FEEDER_UNMASK_EN to add the PlainxDO debug port with the recombined output byte.
module masked_sbox_feeder #(
  parameter int SHARES  = 2,
  parameter int LATENCY = 4,
  parameter int RNDZ_W  = 22,
  parameter int RNDB_W  = 40
) (
  input  logic                         ClkxCI,
  input  logic                         RstxRI,
  input  logic [127:0]                 SeedxDI,
  input  logic                         SeedValidxSI,
  input  logic [7:0]                   InxDI,
  input  logic                         InValidxSI,
  output logic                         InReadyxSO,
  output logic [8*SHARES-1:0]          SboxXxDO,
  output logic [RNDZ_W-1:0]            RandomZxDO,
  output logic [RNDB_W-1:0]            RandomBxDO,
  input  logic [8*SHARES-1:0]          SboxQxDI,
  output logic [8*SHARES-1:0]          OutxDO,
  output logic                         OutValidxSO,
`ifdef SBOX_FEEDER_UNMASK_EN
  output logic [7:0]                   PlainxDO,
`endif
  output logic [$clog2(LATENCY+2)-1:0] InFlightxDO
);

  localparam int IFW    = $clog2(LATENCY+2);
  localparam int MASK_W = 8*(SHARES-1);

  if (SHARES < 2) begin : g_bad_shares
    $error("masked_sbox_feeder: SHARES must be at least 2");
  end
  if (MASK_W + RNDZ_W + RNDB_W > 128) begin : g_bad_rnd
    $error("masked_sbox_feeder: randomness demand exceeds 128 PRNG bits");
  end

  typedef enum logic [1:0] {UNSEEDED, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [127:0]          prng_q, prng_d, prng_step;
  logic [127:0]          pend_q, pend_d;
  logic [127:0]          seed_fix, load_val;
  logic [31:0]           w0, w1, w2, w3, t;
  logic [8*SHARES-1:0]   x_q, x_d;
  logic [8*SHARES-1:0]   out_q, out_d;
  logic [LATENCY:0]      tag_q, tag_d;
  logic                  ov_q;
  logic [IFW-1:0]        infl_q, infl_d;
  logic [7:0]            mfold;
  logic                  in_ready, seed_load, adv, pend_we;
  logic                  accept, drained, tag_exit;

  assign seed_fix = (SeedxDI == 128'h0) ? 128'h1 : SeedxDI;
  assign drained  = (infl_q == '0);
  assign accept   = InValidxSI & in_ready;
  assign tag_exit = tag_q[LATENCY];

  // xorshift128, w0 in the low word
  assign w0 = prng_q[31:0];
  assign w1 = prng_q[63:32];
  assign w2 = prng_q[95:64];
  assign w3 = prng_q[127:96];
  assign t  = w0 ^ (w0 << 11);
  assign prng_step = {w3 ^ (w3 >> 19) ^ t ^ (t >> 8), w3, w2, w1};

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) state_q <= UNSEEDED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNSEEDED: if (SeedValidxSI) state_d = RUN;
      RUN:      if (SeedValidxSI) state_d = DRAIN;
      DRAIN:    if (drained)      state_d = RUN;
      default:                    state_d = UNSEEDED;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    seed_load = 1'b0;
    adv       = 1'b0;
    pend_we   = 1'b0;
    load_val  = pend_q;
    unique case (1'b1)
      (state_q == UNSEEDED): begin
        seed_load = SeedValidxSI;
        load_val  = seed_fix;
      end
      (state_q == RUN): begin
        in_ready = 1'b1;
        adv      = 1'b1;
        pend_we  = SeedValidxSI;
      end
      (state_q == DRAIN): begin
        adv       = 1'b1;
        pend_we   = SeedValidxSI;
        seed_load = drained;
        // a seed arriving on the reload cycle wins over the older pending one
        if (SeedValidxSI) load_val = seed_fix;
      end
      default: ;
    endcase
  end

  always_comb begin
    prng_d = prng_q;
    if (seed_load) prng_d = load_val;
    else if (adv)  prng_d = prng_step;
    pend_d = pend_we ? seed_fix : pend_q;
  end

  // share 0 carries the data; idle cycles feed fresh shares of zero
  always_comb begin
    mfold = 8'h00;
    for (int s = 1; s < SHARES; s++) mfold ^= prng_d[8*(s-1) +: 8];
    x_d = '0;
    x_d[8*SHARES-1:8] = prng_d[MASK_W-1:0];
    x_d[7:0] = (accept ? InxDI : 8'h00) ^ mfold;
  end

  always_comb begin
    tag_d  = {tag_q[LATENCY-1:0], accept};
    out_d  = tag_exit ? SboxQxDI : out_q;
    infl_d = infl_q + IFW'(accept) - IFW'(ov_q);
  end

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      prng_q <= '0;
      pend_q <= '0;
      x_q    <= '0;
      tag_q  <= '0;
      out_q  <= '0;
      ov_q   <= 1'b0;
      infl_q <= '0;
    end else begin
      prng_q <= prng_d;
      pend_q <= pend_d;
      x_q    <= x_d;
      tag_q  <= tag_d;
      out_q  <= out_d;
      ov_q   <= tag_exit;
      infl_q <= infl_d;
    end
  end

`ifdef SBOX_FEEDER_UNMASK_EN
  logic [7:0] plain_q, plain_d;

  always_comb begin
    plain_d = 8'h00;
    for (int s = 0; s < SHARES; s++) plain_d ^= SboxQxDI[8*s +: 8];
    if (!tag_exit) plain_d = plain_q;
  end

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) plain_q <= 8'h00;
    else        plain_q <= plain_d;
  end

  assign PlainxDO = plain_q;
`endif

  assign InReadyxSO  = in_ready;
  assign SboxXxDO    = x_q;
  assign RandomZxDO  = prng_q[MASK_W +: RNDZ_W];
  assign RandomBxDO  = prng_q[MASK_W+RNDZ_W +: RNDB_W];
  assign OutxDO      = out_q;
  assign OutValidxSO = ov_q;
  assign InFlightxDO = infl_q;

endmodule

// File: tb/tb_masked_sbox_feeder.sv
// Bench for masked_sbox_feeder: behavioural masked S-box, scoreboard queue and
// directed stimulus covering seeding, streaming, reseed drain and async reset.
module tb_masked_sbox_feeder;
  localparam int SH  = 2;
  localparam int L   = 4;
  localparam int ZW  = 22;
  localparam int BW  = 40;
  localparam int IFW = $clog2(L+2);
  localparam int OBS = 8*(SH-1) + ZW + BW;

  logic           clk = 1'b0;
  logic           rst;
  logic [127:0]   seed;
  logic           seed_v;
  logic [7:0]     din;
  logic           in_v;
  logic           in_rdy;
  logic [8*SH-1:0] sx, sq, outd;
  logic [ZW-1:0]  rz;
  logic [BW-1:0]  rb;
  logic           out_v;
  logic [IFW-1:0] infl;
`ifdef SBOX_FEEDER_UNMASK_EN
  logic [7:0]     plain;
`endif

  masked_sbox_feeder #(.SHARES(SH), .LATENCY(L), .RNDZ_W(ZW), .RNDB_W(BW)) dut (
    .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed), .SeedValidxSI(seed_v),
    .InxDI(din), .InValidxSI(in_v), .InReadyxSO(in_rdy),
    .SboxXxDO(sx), .RandomZxDO(rz), .RandomBxDO(rb), .SboxQxDI(sq),
    .OutxDO(outd), .OutValidxSO(out_v),
`ifdef SBOX_FEEDER_UNMASK_EN
    .PlainxDO(plain),
`endif
    .InFlightxDO(infl)
  );

  always #5 clk = ~clk;

  logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef struct {
    logic [7:0] v;
    int         cyc;
    bit         mchk;
    logic [7:0] m;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   nout   = 0;
  int   nchg   = 0;
  int   peak   = 0;
  logic [7:0] last_sh1 = 8'h00;

  function automatic logic [7:0] fold(input logic [8*SH-1:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int s = 0; s < SH; s++) r ^= v[8*s +: 8];
    return r;
  endfunction

  function automatic logic [127:0] xs(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, tt;
    {a3, a2, a1, a0} = s;
    tt = a0 ^ (a0 << 11);
    return {a3 ^ (a3 >> 19) ^ tt ^ (tt >> 8), a3, a2, a1};
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural masked S-box: L-cycle pipe, share 0 re-blinded by the other shares
  logic [8*SH-1:0] pipe [L];
  always @(posedge clk) begin
    logic [7:0]      p;
    logic [8*SH-1:0] qv;
    p  = fold(sx);
    qv = sx;
    qv[7:0] = SBOX[p] ^ p ^ sx[7:0];
    pipe[0] <= qv;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign sq = pipe[L-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (int'(infl) > peak) peak = int'(infl);
  end

  // Monitor: every output pulse must match the oldest outstanding byte
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] pv, s1;
    if (!rst && out_v) begin
      pv = fold(outd);
      s1 = outd[15:8];
      chk(q.size() != 0, "spurious_out", pv, 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(pv == e.v, "out_value", pv, e.v);
        chk(cyc == e.cyc + L + 2, "out_latency", cyc, e.cyc + L + 2);
        if (e.mchk) chk(s1 == e.m, "out_mask", s1, e.m);
`ifdef SBOX_FEEDER_UNMASK_EN
        chk(plain == e.v, "plain_port", plain, e.v);
`endif
      end
      if (s1 != last_sh1) nchg++;
      last_sh1 = s1;
      nout++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] ev,
                      input bit mc, input logic [7:0] m);
    din  = b;
    in_v = 1'b1;
    chk(in_rdy == 1'b1, "in_ready_run", in_rdy, 1);
    if (in_rdy) q.push_back('{v: ev, cyc: cyc, mchk: mc, m: m});
    step();
  endtask

  task automatic chk_prng(input logic [127:0] model, input string nm);
    logic [OBS-1:0] o, e;
    o = {rb, rz, sx[8*SH-1:8]};
    e = model[OBS-1:0];
    chk(o == e, nm, o, e);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 100 && q.size() != 0; k++) step();
    chk(q.size() == 0, "drain_timeout", q.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] model, nm, sa, sb;
    int           n0, c0;
    rst = 1'b1; seed = '0; seed_v = 1'b0; din = 8'h00; in_v = 1'b0;
    repeat (2) step();
    chk(in_rdy == 1'b0, "rst_ready", in_rdy, 0);
    chk(out_v == 1'b0, "rst_outvalid", out_v, 0);
    chk(outd == '0, "rst_out", outd, 0);
    chk(infl == '0, "rst_inflight", infl, 0);
    chk(sx == '0, "rst_sboxx", sx, 0);
    rst = 1'b0;

    // unseeded: valid held, nothing accepted
    din = 8'h5a; in_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk(in_rdy == 1'b0, "unseeded_ready", in_rdy, 0);
    end
    chk(infl == '0, "unseeded_inflight", infl, 0);
    in_v = 1'b0;

    // seed, check PRNG words, one byte 0x00 -> 0x63
    seed = 128'h0123456789abcdef0123456789abcdef; seed_v = 1'b1;
    step();
    seed_v = 1'b0;
    model = seed;
    chk_prng(model, "prng_seed");
    step(); model = xs(model); chk_prng(model, "prng_step1");
    step(); model = xs(model); chk_prng(model, "prng_step2");
    nm = xs(model);
    send(8'h00, 8'h63, 1'b1, nm[7:0]);
    model = nm;
    in_v = 1'b0;
    wait_empty();

    // 256 bytes back to back
    peak = 0; n0 = nout;
    for (int i = 0; i < 256; i++) send(8'(i), SBOX[i], 1'b0, 8'h00);
    in_v = 1'b0;
    wait_empty();
    chk(peak == L + 2, "inflight_peak", peak, L + 2);
    chk(nout - n0 == 256, "stream_count", nout - n0, 256);

    // reseed with 3 bytes in flight; second seed overwrites pending
    send(8'h53, 8'hed, 1'b0, 8'h00);
    send(8'hff, 8'h16, 1'b0, 8'h00);
    send(8'h11, 8'h82, 1'b0, 8'h00);
    in_v = 1'b0;
    sa = 128'hdeadbeef_cafef00d_13572468_9abcdef0;
    sb = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    seed = sa; seed_v = 1'b1;
    step();
    chk(in_rdy == 1'b0, "reseed_ready_drop", in_rdy, 0);
    chk(infl == 3, "reseed_inflight", infl, 3);
    seed = sb;
    step();
    seed_v = 1'b0;
    for (int k = 0; k < 20 && infl != 0; k++) step();
    chk(infl == '0, "reseed_drain", infl, 0);
    chk(in_rdy == 1'b0, "reseed_ready_hold", in_rdy, 0);
    step();
    chk(in_rdy == 1'b1, "reseed_ready_back", in_rdy, 1);
    model = sb;
    chk_prng(model, "prng_pending_seed");
    nm = xs(model);
    send(8'h00, 8'h63, 1'b1, nm[7:0]);
    in_v = 1'b0;
    wait_empty();

    // async reset with 4 bytes in flight
    for (int i = 1; i <= 4; i++) send(8'(i), SBOX[i], 1'b0, 8'h00);
    in_v = 1'b0;
    chk(infl == 4, "prerst_inflight", infl, 4);
    #3 rst = 1'b1;
    #1;
    chk(out_v == 1'b0, "arst_outvalid", out_v, 0);
    chk(outd == '0, "arst_out", outd, 0);
    chk(infl == '0, "arst_inflight", infl, 0);
    chk(in_rdy == 1'b0, "arst_ready", in_rdy, 0);
    chk(sx == '0, "arst_sboxx", sx, 0);
    chk(rz == '0, "arst_randz", rz, 0);
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    in_v = 1'b1; din = 8'h77;
    for (int i = 0; i < 12; i++) begin
      step();
      chk(in_rdy == 1'b0, "postrst_unseeded", in_rdy, 0);
    end
    in_v = 1'b0;

    // zero seed runs from 1
    seed = '0; seed_v = 1'b1;
    step();
    seed_v = 1'b0;
    model = 128'h1;
    chk_prng(model, "prng_zero_seed");
    step(); model = xs(model); chk_prng(model, "prng_zero_step");
    c0 = nchg;
    for (int i = 0; i < 20; i++) send(8'haa, 8'hac, 1'b0, 8'h00);
    in_v = 1'b0;
    wait_empty();
    chk(nchg > c0, "share_nonconst", nchg - c0, 1);

    chk(q.size() == 0, "final_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
